// File: rtl/rr_arbiter_idx8_pkg.sv
// Shared types and sizes for the eight-way round-robin arbiter.
// Imported by the interface, the picker and the top.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter_idx8_if.sv
// Request/grant bundle between requesters and the arbiter.
// Handshake: a grant is live while out_valid=1 and out_idx is stable
// for its whole duration. in_done is sampled only while out_valid=1.
interface rr_arbiter_idx8_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] in_req;
  logic             in_done;
  logic             out_valid;
  idx_t             out_idx;
  logic             out_timeout;

  modport master (
    output in_req,
    output in_done,
    input  out_valid,
    input  out_idx,
    input  out_timeout
  );

  modport slave (
    input  in_req,
    input  in_done,
    output out_valid,
    output out_idx,
    output out_timeout
  );
endinterface

// File: rtl/rr_arbiter_idx8_pick8.sv
// Round-robin pick: rotate requests so ptr sits at bit 0, take the lowest
// set bit, then add ptr back to get the absolute index.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] in_req,
  input  idx_t             ptr,
  output idx_t             pick,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  idx_t             off;

  always_comb begin
    rot = N_REQ'({in_req, in_req} >> ptr);
    off = '0;
    // Descending scan so the lowest set bit is the last assignment.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = idx_t'(i);
    end
  end

  assign pick = ptr + off;
  assign any  = |in_req;

endmodule

// File: rtl/rr_arbiter_idx8.sv
// Eight-requester non-preemptive round-robin arbiter with registered
// grant index, done-or-timeout release and a one-idle-cycle bubble.
module rr_arbiter_idx8
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  rr_arbiter_idx8_if.slave   bus,
  output arb_state_t         dbg_state,
  output idx_t               dbg_ptr
);

  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

  arb_state_t state, state_n;
  idx_t       ptr, ptr_n;
  logic [7:0] tcnt, tcnt_n;
  logic       valid_q, valid_n;
  idx_t       idx_q, idx_n;
  logic       to_q, to_n;

  idx_t pick;
  logic any;

  rr_pick8 u_pick (
    .in_req (bus.in_req),
    .ptr    (ptr),
    .pick   (pick),
    .any    (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      tcnt    <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      tcnt    <= tcnt_n;
      valid_q <= valid_n;
      idx_q   <= idx_n;
      to_q    <= to_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    tcnt_n  = tcnt;
    valid_n = valid_q;
    idx_n   = idx_q;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          idx_n   = pick;
          valid_n = 1'b1;
          tcnt_n  = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        tcnt_n = (tcnt == 8'hFF) ? tcnt : tcnt + 8'd1;
        // Done takes priority, so a coinciding timeout raises no pulse.
        if (bus.in_done) begin
          valid_n = 1'b0;
          ptr_n   = idx_q + idx_t'(1);
          state_n = IDLE;
        end else if (tcnt == TLIM) begin
          valid_n = 1'b0;
          ptr_n   = idx_q + idx_t'(1);
          to_n    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_idx     = idx_q;
  assign bus.out_timeout = to_q;
  assign dbg_state       = state;
  assign dbg_ptr         = ptr;

endmodule

// File: tb/tb_rr_arbiter_idx8.sv
// Directed bench for rr_arbiter_idx8: expected grant indices are queued
// when requests are driven and popped when a grant appears.
module tb_rr_arbiter_idx8;
  import arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  arb_state_t dbg_state;
  idx_t       dbg_ptr;

  rr_arbiter_idx8_if arb_if ();

  rr_arbiter_idx8 #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (arb_if.slave),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [IDX_W-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic grant_check(input string tag);
    logic [IDX_W-1:0] e;
    chk({tag, "_valid"}, 32'(arb_if.out_valid), 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_idx"}, 32'(arb_if.out_idx), 32'(e));
    end
  endtask

  task automatic release_done();
    arb_if.in_done = 1'b1;
    tick();
    arb_if.in_done = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int hi_cnt;
    int pulses;
    arb_if.in_req  = '0;
    arb_if.in_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_valid", 32'(arb_if.out_valid), 32'd0);
    chk("rst_idx", 32'(arb_if.out_idx), 32'd0);
    chk("rst_timeout", 32'(arb_if.out_timeout), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_ptr", 32'(dbg_ptr), 32'd0);

    // single request, done two cycles into the grant
    arb_if.in_req = 8'h08;
    exp_q.push_back(3'd3);
    tick();
    grant_check("single");
    arb_if.in_req = 8'h00;
    tick();
    tick();
    chk("single_hold_idx", 32'(arb_if.out_idx), 32'd3);
    release_done();
    chk("single_rel_valid", 32'(arb_if.out_valid), 32'd0);
    chk("single_rel_ptr", 32'(dbg_ptr), 32'd4);
    chk("single_rel_keep_idx", 32'(arb_if.out_idx), 32'd3);
    chk("single_rel_timeout", 32'(arb_if.out_timeout), 32'd0);

    // asynchronous reset in the middle of a grant to 5
    arb_if.in_req = 8'h20;
    exp_q.push_back(3'd5);
    tick();
    grant_check("pre_reset");
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(arb_if.out_valid), 32'd0);
    chk("async_rst_idx", 32'(arb_if.out_idx), 32'd0);
    chk("async_rst_timeout", 32'(arb_if.out_timeout), 32'd0);
    chk("async_rst_ptr", 32'(dbg_ptr), 32'd0);
    tick();
    rst = 1'b0;
    exp_q.push_back(3'd5);
    tick();
    grant_check("post_reset");
    arb_if.in_req = 8'h00;
    release_done();
    pulse_reset();

    // fairness with every requester active
    arb_if.in_req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back(IDX_W'(k % 8));
      tick();
      grant_check("rr");
      arb_if.in_done = 1'b1;
      tick();
      arb_if.in_done = 1'b0;
      chk("rr_bubble", 32'(arb_if.out_valid), 32'd0);
    end
    chk("rr_ptr", 32'(dbg_ptr), 32'd1);

    // wrap and skip
    arb_if.in_req = 8'h40;
    exp_q.push_back(3'd6);
    tick();
    grant_check("wrap_a");
    arb_if.in_req = 8'h41;
    release_done();
    chk("wrap_ptr7", 32'(dbg_ptr), 32'd7);
    exp_q.push_back(3'd0);
    tick();
    grant_check("wrap_b");
    release_done();
    chk("wrap_ptr1", 32'(dbg_ptr), 32'd1);
    exp_q.push_back(3'd6);
    tick();
    grant_check("wrap_c");
    arb_if.in_req = 8'h00;
    release_done();

    // in_done while idle has no effect
    arb_if.in_done = 1'b1;
    tick();
    tick();
    arb_if.in_done = 1'b0;
    chk("idle_done_valid", 32'(arb_if.out_valid), 32'd0);
    chk("idle_done_ptr", 32'(dbg_ptr), 32'd7);

    // timeout on a grant to 2
    arb_if.in_req = 8'h04;
    exp_q.push_back(3'd2);
    tick();
    grant_check("to_grant");
    arb_if.in_req = 8'h00;
    hi_cnt = 1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (arb_if.out_timeout) pulses++;
      if (!arb_if.out_valid) break;
      hi_cnt++;
    end
    chk("to_valid_cycles", 32'(hi_cnt), 32'd16);
    chk("to_pulse_at_release", 32'(arb_if.out_timeout), 32'd1);
    chk("to_ptr", 32'(dbg_ptr), 32'd3);
    tick();
    if (arb_if.out_timeout) pulses++;
    chk("to_pulse_count", 32'(pulses), 32'd1);
    chk("to_pulse_low_after", 32'(arb_if.out_timeout), 32'd0);

    // non-preemption, then done colliding with the timeout cycle
    arb_if.in_req = 8'h10;
    exp_q.push_back(3'd4);
    tick();
    grant_check("np_grant");
    arb_if.in_req = 8'h02;
    tick();
    chk("np_hold_idx", 32'(arb_if.out_idx), 32'd4);
    for (int c = 0; c < 14; c++) tick();
    chk("np_late_valid", 32'(arb_if.out_valid), 32'd1);
    chk("np_late_idx", 32'(arb_if.out_idx), 32'd4);
    release_done();
    chk("coll_valid", 32'(arb_if.out_valid), 32'd0);
    chk("coll_timeout", 32'(arb_if.out_timeout), 32'd0);
    chk("coll_ptr", 32'(dbg_ptr), 32'd5);
    exp_q.push_back(3'd1);
    tick();
    grant_check("coll_next");
    chk("coll_next_timeout", 32'(arb_if.out_timeout), 32'd0);
    arb_if.in_req = 8'h00;
    release_done();

    // final report
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
